elevator_request_scheduler: RTL and testbench
=============================================

# elevator_request_scheduler

Upstream stage of `Elevator_Control`. Latches hall/car floor calls into a pending-request bitmap and applies a SCAN (collective) policy: keep serving in the current direction, then reverse. Drives the controller's `req_floor` one target at a time. Retires each request when the car reports a stop at that floor.

## Interface
- `NUM_FLOORS`, 64: number of serviceable floors (0..NUM_FLOORS-1), at most 128.
- `DWELL_CYCLES`, 8: cycles held after an arrival before the next target is issued (≥1).
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `call_valid` in 1: one-cycle call strobe.
- `call_floor` in 7: requested floor, sampled when `call_valid`=1.
- `car_floor` in 7: current car floor (controller `y`).
- `car_stop` in 1: car stopped at `car_floor` (controller `stop[0]`).
- `req_floor` out 7: target floor to controller.
- `req_valid` out 1: `req_floor` is a live target.
- `dir_up` / `dir_down` out 1: current service direction; both 0 when idle.
- `call_err` out 1: one-cycle pulse, out-of-range call rejected.
- `pending` out NUM_FLOORS: request bitmap, for display and debug.

## Operation
- States: IDLE, SERVE_UP, SERVE_DOWN, DWELL.
- **Call latch:** `call_valid` with `call_floor` < NUM_FLOORS sets `pending[call_floor]`. Duplicates are idempotent. `call_floor` ≥ NUM_FLOORS pulses `call_err` and leaves the bitmap unchanged.
- **IDLE:** when any bit is pending, pick the nearest floor to `car_floor`. A distance tie goes to the upper floor. Go to SERVE_UP if target ≥ `car_floor`, else SERVE_DOWN.
- **SERVE_UP target:** lowest pending floor ≥ `car_floor`.
  - If none, but a floor below is pending, go to SERVE_DOWN.
  - If nothing is pending, go to IDLE.
- **SERVE_DOWN target:** highest pending floor ≤ `car_floor`, with the symmetric fallback.
- **Retarget:** a new call lying between the car and the current target, in the current direction, replaces `req_floor` immediately. Calls behind the car wait for the reversal.
- **Arrival:** `req_valid` & `car_stop` & `car_floor`==`req_floor` does the following:
  - clears that bit;
  - drops `req_valid`;
  - enters DWELL and holds the direction.
- **DWELL:**
  - Counts DWELL_CYCLES, then re-evaluates per the current direction's rules; returns to IDLE if nothing is pending.
  - A call to `car_floor` during DWELL is absorbed (door is open) and is not latched.
- **Simultaneous set and clear of the same floor in one cycle:** clear wins only on the arrival cycle. Otherwise set wins.
- **Reset mid-operation:** bitmap cleared, state IDLE, all requests lost.

## Timing
- Reset values: `req_floor`=0, `req_valid`=0, `dir_up`=0, `dir_down`=0, `call_err`=0, `pending`=0, state IDLE, dwell counter 0.
- Call to bitmap: `pending` bit visible 1 cycle after the `call_valid` edge.
- Call to target: `req_floor`/`req_valid` registered, valid 2 cycles after `call_valid` when the scheduler is idle.
- Arrival to clear: bit cleared and `req_valid`=0 on the cycle after the arrival condition.
- Arrival to next target: next `req_valid` asserts DWELL_CYCLES+1 cycles after the arrival cycle.
- `req_floor` changes only while in SERVE_UP/SERVE_DOWN, on a retarget or state entry. It holds its last value in DWELL and IDLE.
- `call_err` is registered, 1 cycle after the offending `call_valid`.
- `car_floor` ≥ NUM_FLOORS is treated as NUM_FLOORS-1 for the search. No error is flagged.

## Structure
- `elevator_pkg` holds:
  - `FLOOR_W`=7;
  - default `NUM_FLOORS`;
  - the state enum `sched_state_t` {IDLE, SERVE_UP, SERVE_DOWN, DWELL};
  - direction constants.
  These are shared with `Elevator_Control` and the top level.
- Sub-module `floor_search`: purely combinational. Given the bitmap and `car_floor`, it returns:
  - lowest set bit ≥ car, with a found flag;
  - highest set bit ≤ car, with a found flag;
  - nearest-with-tie-up.

  The scheduler instantiates it once. It keeps the FSM file small and is unit-testable on its own.

## Test plan
- **Reset and first call:** reset_n low then high; call 25 with car at 0 → `req_floor`=25, `req_valid`=1, `dir_up`=1 two cycles later. `car_floor`=25 with `car_stop` → bit 25 clear, DWELL 8 cycles, then IDLE with all outputs 0 except `req_floor`=25.
- **Retarget:** car at 10 heading to 25 (SERVE_UP); call 15 → `req_floor`=15 within 2 cycles. After arrival at 15 and dwell → `req_floor`=25.
- **Reversal:** car at 10 going up to 37; call 3 → target stays 37. After arrival at 37 and dwell → `dir_down`=1, `req_floor`=3.
- **Bounds:** call 70 with NUM_FLOORS=64 → `call_err` pulse, `pending` unchanged. Call 63 accepted. Call 0 at car 5 while idle → SERVE_DOWN, target 0.
- **Tie and absorb:** car at 20, idle, calls 18 and 22 in the same window → target 22 (tie goes up). Call 22 during DWELL at 22 → not latched.
- **Reset mid-run:** reset_n pulsed while three calls are pending → bitmap 0, `req_valid`=0, IDLE, asynchronously without waiting for a clock edge.

Source files
------------

// File: rtl/elevator_request_scheduler_pkg.sv
// Shared definitions for the elevator request scheduler and Elevator_Control:
// floor width, default sizing, scheduler state encoding and direction codes.
package elevator_pkg;

  localparam int FLOOR_W          = 7;
  localparam int NUM_FLOORS_DEF   = 64;
  localparam int DWELL_CYCLES_DEF = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_UP   = 2'd1,
    SERVE_DOWN = 2'd2,
    DWELL      = 2'd3
  } sched_state_t;

  // Direction is held as {up, down}; both clear means idle.
  typedef logic [1:0] dir_t;
  localparam dir_t DIR_NONE = 2'b00;
  localparam dir_t DIR_UP   = 2'b10;
  localparam dir_t DIR_DOWN = 2'b01;

endpackage

// File: rtl/elevator_request_scheduler_floor_search.sv
// Combinational search over the pending bitmap relative to the car position:
// next floor at/above, next floor at/below, and the nearest (ties go up).
module floor_search
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF
) (
  input  logic [NUM_FLOORS-1:0] i_pending,
  input  logic [FLOOR_W-1:0]    i_car_floor,
  output logic                  o_up_found,
  output logic [FLOOR_W-1:0]    o_up_floor,
  output logic                  o_dn_found,
  output logic [FLOOR_W-1:0]    o_dn_floor,
  output logic                  o_near_found,
  output logic [FLOOR_W-1:0]    o_near_floor,
  output logic                  o_near_up
);

  logic [FLOOR_W-1:0] w_car;
  logic [FLOOR_W-1:0] w_up_dist;
  logic [FLOOR_W-1:0] w_dn_dist;

  // A car position past the top floor is searched as if at the top floor.
  assign w_car = (32'(i_car_floor) >= NUM_FLOORS) ? FLOOR_W'(NUM_FLOORS - 1) : i_car_floor;

  always_comb begin
    o_up_found = 1'b0;
    o_up_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (i_pending[i] && (FLOOR_W'(i) >= w_car)) begin
        o_up_found = 1'b1;
        o_up_floor = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    o_dn_found = 1'b0;
    o_dn_floor = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i_pending[i] && (FLOOR_W'(i) <= w_car)) begin
        o_dn_found = 1'b1;
        o_dn_floor = FLOOR_W'(i);
      end
    end
  end

  assign w_up_dist    = o_up_floor - w_car;
  assign w_dn_dist    = w_car - o_dn_floor;
  assign o_near_up    = o_up_found && (!o_dn_found || (w_up_dist <= w_dn_dist));
  assign o_near_found = o_up_found || o_dn_found;
  assign o_near_floor = o_near_up ? o_up_floor : o_dn_floor;

endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN scheduler: latches floor calls into a bitmap, issues one target at a
// time in the current direction, retires it on arrival and dwells before moving on.
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
  parameter int DWELL_CYCLES = DWELL_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  car_stop,
  output logic [FLOOR_W-1:0]    req_floor,
  output logic                  req_valid,
  output logic                  dir_up,
  output logic                  dir_down,
  output logic                  call_err,
  output logic [NUM_FLOORS-1:0] pending,
  output sched_state_t          state_dbg
);

  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  sched_state_t          r_state;
  logic [NUM_FLOORS-1:0] r_pending;
  logic [FLOOR_W-1:0]    r_req_floor;
  logic                  r_req_valid;
  dir_t                  r_dir;
  logic                  r_call_err;
  logic [DWELL_W-1:0]    r_dwell;

  sched_state_t          w_state_nx;
  logic [FLOOR_W-1:0]    w_req_floor_nx;
  logic                  w_req_valid_nx;
  dir_t                  w_dir_nx;
  logic [DWELL_W-1:0]    w_dwell_nx;
  logic                  w_clr_en;
  logic                  w_eval_up;
  logic                  w_eval_dn;

  logic                  w_call_in_range;
  logic                  w_call_ok;
  logic                  w_arrive;
  logic [NUM_FLOORS-1:0] w_set_mask;
  logic [NUM_FLOORS-1:0] w_clr_mask;

  logic                  w_up_found;
  logic [FLOOR_W-1:0]    w_up_floor;
  logic                  w_dn_found;
  logic [FLOOR_W-1:0]    w_dn_floor;
  logic                  w_near_found;
  logic [FLOOR_W-1:0]    w_near_floor;
  logic                  w_near_up;

  floor_search #(
    .NUM_FLOORS (NUM_FLOORS)
  ) u_floor_search (
    .i_pending    (r_pending),
    .i_car_floor  (car_floor),
    .o_up_found   (w_up_found),
    .o_up_floor   (w_up_floor),
    .o_dn_found   (w_dn_found),
    .o_dn_floor   (w_dn_floor),
    .o_near_found (w_near_found),
    .o_near_floor (w_near_floor),
    .o_near_up    (w_near_up)
  );

  assign w_call_in_range = 32'(call_floor) < NUM_FLOORS;
  // With the door open, a call for the current floor is already served.
  assign w_call_ok = call_valid && w_call_in_range &&
                     !((r_state == DWELL) && (call_floor == car_floor));
  assign w_arrive  = r_req_valid && car_stop && (car_floor == r_req_floor);

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      w_set_mask[i] = w_call_ok && (call_floor == FLOOR_W'(i));
      w_clr_mask[i] = w_clr_en && (r_req_floor == FLOOR_W'(i));
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_req_floor_nx = r_req_floor;
    w_req_valid_nx = r_req_valid;
    w_dir_nx       = r_dir;
    w_dwell_nx     = r_dwell;
    w_clr_en       = 1'b0;
    w_eval_up      = 1'b0;
    w_eval_dn      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_near_found) begin
          w_req_floor_nx = w_near_floor;
          w_req_valid_nx = 1'b1;
          w_state_nx     = w_near_up ? SERVE_UP : SERVE_DOWN;
          w_dir_nx       = w_near_up ? DIR_UP : DIR_DOWN;
        end
      end
      SERVE_UP, SERVE_DOWN: begin
        if (w_arrive) begin
          w_clr_en       = 1'b1;
          w_req_valid_nx = 1'b0;
          w_dwell_nx     = '0;
          w_state_nx     = DWELL;
        end else begin
          w_eval_up = (r_state == SERVE_UP);
          w_eval_dn = (r_state == SERVE_DOWN);
        end
      end
      DWELL: begin
        if (r_dwell == DWELL_LAST) begin
          w_dwell_nx = '0;
          w_eval_up  = (r_dir != DIR_DOWN);
          w_eval_dn  = (r_dir == DIR_DOWN);
        end else begin
          w_dwell_nx = r_dwell + DWELL_W'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase

    // Re-evaluation keeps the direction while work remains ahead, else reverses.
    if ((w_eval_up && w_up_found) || (w_eval_dn && !w_dn_found && w_up_found)) begin
      w_state_nx     = SERVE_UP;
      w_dir_nx       = DIR_UP;
      w_req_floor_nx = w_up_floor;
      w_req_valid_nx = 1'b1;
    end else if ((w_eval_dn && w_dn_found) || (w_eval_up && !w_up_found && w_dn_found)) begin
      w_state_nx     = SERVE_DOWN;
      w_dir_nx       = DIR_DOWN;
      w_req_floor_nx = w_dn_floor;
      w_req_valid_nx = 1'b1;
    end else if (w_eval_up || w_eval_dn) begin
      w_state_nx     = IDLE;
      w_dir_nx       = DIR_NONE;
      w_req_valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_req_floor <= '0;
      r_req_valid <= 1'b0;
      r_dir       <= DIR_NONE;
      r_call_err  <= 1'b0;
      r_dwell     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_pending   <= (r_pending | w_set_mask) & ~w_clr_mask;
      r_req_floor <= w_req_floor_nx;
      r_req_valid <= w_req_valid_nx;
      r_dir       <= w_dir_nx;
      r_call_err  <= call_valid && !w_call_in_range;
      r_dwell     <= w_dwell_nx;
    end
  end

  assign req_floor = r_req_floor;
  assign req_valid = r_req_valid;
  assign dir_up    = (r_dir == DIR_UP);
  assign dir_down  = (r_dir == DIR_DOWN);
  assign call_err  = r_call_err;
  assign pending   = r_pending;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: single-call vector table, directed
// multi-cycle sequences, and a random run against a behavioural SCAN model.
module tb_elevator_request_scheduler;
  import elevator_pkg::*;

  localparam int NF = 64;
  localparam int DW = 8;

  logic          clk;
  logic          reset_n;
  logic          call_valid;
  logic [6:0]    call_floor;
  logic [6:0]    car_floor;
  logic          car_stop;
  logic [6:0]    req_floor;
  logic          req_valid;
  logic          dir_up;
  logic          dir_down;
  logic          call_err;
  logic [NF-1:0] pending;
  sched_state_t  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  elevator_request_scheduler #(
    .NUM_FLOORS   (NF),
    .DWELL_CYCLES (DW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .call_valid (call_valid),
    .call_floor (call_floor),
    .car_floor  (car_floor),
    .car_stop   (car_stop),
    .req_floor  (req_floor),
    .req_valid  (req_valid),
    .dir_up     (dir_up),
    .dir_down   (dir_down),
    .call_err   (call_err),
    .pending    (pending),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  sched_state_t  m_mode;
  logic [NF-1:0] m_pending;
  int            m_target;
  logic          m_valid;
  logic          m_up;
  logic          m_down;
  logic          m_err;
  int            m_dwell_left;

  task automatic model_reset();
    m_mode       = IDLE;
    m_pending    = '0;
    m_target     = 0;
    m_valid      = 1'b0;
    m_up         = 1'b0;
    m_down       = 1'b0;
    m_err        = 1'b0;
    m_dwell_left = 0;
  endtask

  function automatic int lowest_from(input logic [NF-1:0] p, input int c);
    for (int f = c; f < NF; f++) if (p[f]) return f;
    return -1;
  endfunction

  function automatic int highest_to(input logic [NF-1:0] p, input int c);
    for (int f = c; f >= 0; f--) if (p[f]) return f;
    return -1;
  endfunction

  // Nearest pending floor by distance; at equal distance the upper floor wins.
  function automatic int nearest(input logic [NF-1:0] p, input int c);
    for (int d = 0; d < NF; d++) begin
      if (c + d < NF && p[c + d]) return c + d;
      if (c - d >= 0 && p[c - d]) return c - d;
    end
    return -1;
  endfunction

  task automatic model_go(input int tgt, input bit up);
    m_target = tgt;
    m_valid  = 1'b1;
    m_up     = up;
    m_down   = !up;
    m_mode   = up ? SERVE_UP : SERVE_DOWN;
  endtask

  task automatic model_serve(input logic [NF-1:0] p, input int c, input bit going_up);
    int u;
    int d;
    u = lowest_from(p, c);
    d = highest_to(p, c);
    if (going_up && u >= 0)       model_go(u, 1'b1);
    else if (!going_up && d >= 0) model_go(d, 1'b0);
    else if (u >= 0)              model_go(u, 1'b1);
    else if (d >= 0)              model_go(d, 1'b0);
    else begin
      m_mode  = IDLE;
      m_valid = 1'b0;
      m_up    = 1'b0;
      m_down  = 1'b0;
    end
  endtask

  task automatic model_step(input logic cv, input int cf, input int car, input logic stop);
    logic [NF-1:0] p_old;
    int  carc;
    bit  arrive;
    bit  absorb;
    int  t;
    p_old  = m_pending;
    carc   = (car >= NF) ? NF - 1 : car;
    absorb = (m_mode == DWELL) && (cf == car);
    arrive = m_valid && stop && (car == m_target);
    m_err  = cv && (cf >= NF);
    if (cv && cf < NF && !absorb) m_pending[cf] = 1'b1;
    if (arrive) m_pending[m_target] = 1'b0;
    case (m_mode)
      IDLE: begin
        t = nearest(p_old, carc);
        if (t >= 0) model_go(t, t >= carc);
      end
      SERVE_UP, SERVE_DOWN: begin
        if (arrive) begin
          m_mode       = DWELL;
          m_valid      = 1'b0;
          m_dwell_left = DW;
        end else begin
          model_serve(p_old, carc, m_mode == SERVE_UP);
        end
      end
      default: begin
        if (m_dwell_left == 1) model_serve(p_old, carc, !m_down);
        else m_dwell_left--;
      end
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_req_floor", req_floor, m_target[6:0]);
    chk("model_req_valid", req_valid, m_valid);
    chk("model_dir_up", dir_up, m_up);
    chk("model_dir_down", dir_down, m_down);
    chk("model_call_err", call_err, m_err);
    chk("model_pending", pending, m_pending);
    chk("model_state", state_dbg, m_mode);
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    reset_n    = 1'b0;
    call_valid = 1'b0;
    call_floor = '0;
    car_stop   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    check_model();
  endtask

  task automatic tick(input logic cv, input int cf, input int car, input logic stop);
    call_valid = cv;
    call_floor = cf[6:0];
    car_floor  = car[6:0];
    car_stop   = stop;
    @(posedge clk);
    model_step(cv, cf, car, stop);
    @(negedge clk);
    check_model();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int   call_f;
    int   car_f;
    logic exp_err;
    logic exp_valid;
    int   exp_floor;
    logic exp_up;
    logic exp_down;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [NF-1:0] exp_p;
    int car_pos;
    logic cv;
    int cf;
    logic stop;

    vecs[0] = '{25,  0,   1'b0, 1'b1, 25, 1'b1, 1'b0};
    vecs[1] = '{0,   5,   1'b0, 1'b1, 0,  1'b0, 1'b1};
    vecs[2] = '{70,  0,   1'b1, 1'b0, 0,  1'b0, 1'b0};
    vecs[3] = '{63,  0,   1'b0, 1'b1, 63, 1'b1, 1'b0};
    vecs[4] = '{5,   5,   1'b0, 1'b1, 5,  1'b1, 1'b0};
    vecs[5] = '{10,  100, 1'b0, 1'b1, 10, 1'b0, 1'b1};
    vecs[6] = '{127, 3,   1'b1, 1'b0, 0,  1'b0, 1'b0};
    vecs[7] = '{63,  127, 1'b0, 1'b1, 63, 1'b1, 1'b0};
    vecs[8] = '{64,  10,  1'b1, 1'b0, 0,  1'b0, 1'b0};
    vecs[9] = '{40,  41,  1'b0, 1'b1, 40, 1'b0, 1'b1};

    reset_n    = 1'b0;
    call_valid = 1'b0;
    call_floor = '0;
    car_floor  = '0;
    car_stop   = 1'b0;
    model_reset();

    do_reset();
    chk("reset_req_floor", req_floor, 0);
    chk("reset_req_valid", req_valid, 0);
    chk("reset_dir", {dir_up, dir_down}, 0);
    chk("reset_call_err", call_err, 0);
    chk("reset_pending", pending, 0);
    chk("reset_state", state_dbg, IDLE);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      tick(1'b1, vecs[i].call_f, vecs[i].car_f, 1'b0);
      chk("tbl_call_err", call_err, vecs[i].exp_err);
      tick(1'b0, 0, vecs[i].car_f, 1'b0);
      chk("tbl_err_pulse_end", call_err, 0);
      chk("tbl_req_valid", req_valid, vecs[i].exp_valid);
      chk("tbl_req_floor", req_floor, vecs[i].exp_floor);
      chk("tbl_dir_up", dir_up, vecs[i].exp_up);
      chk("tbl_dir_down", dir_down, vecs[i].exp_down);
    end

    // First call, arrival, dwell, back to idle.
    do_reset();
    tick(1'b1, 25, 0, 1'b0);
    chk("s1_pend25", pending[25], 1);
    chk("s1_valid_early", req_valid, 0);
    tick(1'b0, 0, 0, 1'b0);
    chk("s1_req_floor", req_floor, 25);
    chk("s1_req_valid", req_valid, 1);
    chk("s1_dir_up", dir_up, 1);
    tick(1'b0, 0, 25, 1'b1);
    chk("s1_cleared", pending[25], 0);
    chk("s1_valid_drop", req_valid, 0);
    chk("s1_dwell", state_dbg, DWELL);
    repeat (7) tick(1'b0, 0, 25, 1'b1);
    chk("s1_still_dwell", state_dbg, DWELL);
    tick(1'b0, 0, 25, 1'b1);
    chk("s1_idle", state_dbg, IDLE);
    chk("s1_idle_floor", req_floor, 25);
    chk("s1_idle_outs", {req_valid, dir_up, dir_down, call_err}, 0);
    chk("s1_idle_pending", pending, 0);

    // Retarget to an intermediate call in the travel direction.
    do_reset();
    tick(1'b1, 25, 10, 1'b0);
    tick(1'b0, 0, 10, 1'b0);
    chk("s2_first_target", req_floor, 25);
    tick(1'b1, 15, 10, 1'b0);
    tick(1'b0, 0, 10, 1'b0);
    chk("s2_retarget", req_floor, 15);
    tick(1'b0, 0, 15, 1'b1);
    repeat (8) tick(1'b0, 0, 15, 1'b0);
    chk("s2_resume_floor", req_floor, 25);
    chk("s2_resume_valid", req_valid, 1);
    chk("s2_resume_up", dir_up, 1);

    // Call behind the car waits for reversal.
    do_reset();
    tick(1'b1, 37, 10, 1'b0);
    tick(1'b0, 0, 10, 1'b0);
    tick(1'b1, 3, 10, 1'b0);
    tick(1'b0, 0, 10, 1'b0);
    chk("s3_keep_target", req_floor, 37);
    chk("s3_keep_up", dir_up, 1);
    chk("s3_pend3", pending[3], 1);
    tick(1'b0, 0, 37, 1'b1);
    repeat (8) tick(1'b0, 0, 37, 1'b0);
    chk("s3_rev_down", {dir_up, dir_down}, 2'b01);
    chk("s3_rev_floor", req_floor, 3);
    chk("s3_rev_valid", req_valid, 1);

    // Equidistant calls while dwelling at 20 going up, then absorb at 22.
    do_reset();
    tick(1'b1, 20, 20, 1'b0);
    tick(1'b0, 0, 20, 1'b0);
    tick(1'b0, 0, 20, 1'b1);
    tick(1'b1, 18, 20, 1'b1);
    tick(1'b1, 22, 20, 1'b1);
    repeat (6) tick(1'b0, 0, 20, 1'b1);
    chk("s5_pick_up", req_floor, 22);
    chk("s5_dir_up", dir_up, 1);
    tick(1'b0, 0, 22, 1'b1);
    tick(1'b1, 22, 22, 1'b1);
    chk("s5_absorb", pending[22], 0);
    chk("s5_keep18", pending[18], 1);
    repeat (7) tick(1'b0, 0, 22, 1'b1);
    chk("s5_rev_down", dir_down, 1);
    chk("s5_rev_floor", req_floor, 18);

    // Asynchronous reset with three calls pending.
    do_reset();
    tick(1'b1, 5, 30, 1'b0);
    tick(1'b1, 40, 30, 1'b0);
    tick(1'b1, 50, 30, 1'b0);
    tick(1'b0, 0, 30, 1'b0);
    exp_p = '0;
    exp_p[5] = 1'b1;
    exp_p[40] = 1'b1;
    exp_p[50] = 1'b1;
    chk("s6_three_pending", pending, exp_p);
    #2 reset_n = 1'b0;
    #1;
    chk("s6_async_pending", pending, 0);
    chk("s6_async_valid", req_valid, 0);
    chk("s6_async_state", state_dbg, IDLE);
    chk("s6_async_dir", {dir_up, dir_down}, 0);
    @(negedge clk);
    do_reset();

    // Random traffic with a simple car that moves toward the model's target.
    car_pos = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) do_reset();
      cv = ($urandom_range(0, 3) == 0);
      cf = ($urandom_range(0, 4) == 0) ? car_pos : int'($urandom_range(0, 71));
      if (m_valid && car_pos == m_target) stop = ($urandom_range(0, 3) != 0);
      else stop = ($urandom_range(0, 7) == 0);
      tick(cv, cf, car_pos, stop);
      if (m_valid && car_pos != m_target && $urandom_range(0, 1) == 1)
        car_pos += (m_target > car_pos) ? 1 : -1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
